// File: rtl/instr_q_pkg.sv
// instr_q_pkg: shared widths, ISA opcode constants and count-width helper for the prefetch queue
package instr_q_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int OPCODE_W_DEF = 3;
  localparam int DEPTH_DEF    = 4;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_LDA = 3'b101,
    OP_OUT = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH x DATA_W register array with one write port and one asynchronous read port
module iq_storage
  import instr_q_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // contents are never cleared; only the owner's pointers decide what is valid
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end
  assign rd_data = r_mem[rd_addr];
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: FIFO of fetched instruction words feeding the control unit; IR_BYPASS_EN enables empty-queue bypass
module instr_prefetch_queue
  import instr_q_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [DATA_W-1:0]          ir_out,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [DATA_W-OPCODE_W-1:0] operand,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_empty, w_byp, w_push, w_pop, w_clr;
  assign w_empty  = (r_count == '0);
  assign wr_ready = (r_count != CW'(DEPTH));
  assign w_clr    = !rst || flush;
`ifdef IR_BYPASS_EN
  assign w_byp  = w_empty && wr_valid && !flush;
  assign w_push = wr_valid && wr_ready && !(w_byp && ir_ready);
`else
  assign w_byp  = 1'b0;
  assign w_push = wr_valid && wr_ready;
`endif
  assign w_pop    = !w_empty && ir_ready;
  assign ir_valid = !w_empty || w_byp;
  assign ir_out   = !w_empty ? w_rd_data : (w_byp ? wr_data : '0);
  assign opcode   = ir_out[DATA_W-1 -: OPCODE_W];
  assign operand  = ir_out[DATA_W-OPCODE_W-1:0];
  assign count    = r_count;
  iq_storage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (w_push && !w_clr),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );
  // pointer and occupancy tracking; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed and randomized checks of instr_prefetch_queue against a queue-based model
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  logic       clk = 0, rst = 0, flush = 0, wr_valid = 0, ir_ready = 0;
  logic [7:0] wr_data = 0;
  logic       wr_ready, ir_valid;
  logic [7:0] ir_out;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [2:0] count;
  int         vec = 0, err = 0;
  logic [7:0] q[$];

  instr_prefetch_queue #(.DATA_W(8), .OPCODE_W(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out),
    .opcode(opcode), .operand(operand), .count(count)
  );

  always #5 clk = ~clk;

  function automatic bit m_byp();
`ifdef IR_BYPASS_EN
    return q.size() == 0 && wr_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_valid();
    return q.size() != 0 || m_byp();
  endfunction

  function automatic logic [7:0] m_out();
    return q.size() != 0 ? q[0] : (m_byp() ? wr_data : 8'h00);
  endfunction

  task automatic model_edge();
    bit push, pop;
    if (!rst || flush) q.delete();
    else if (m_byp() && ir_ready) begin
    end else begin
      push = wr_valid && q.size() < DEPTH;
      pop  = ir_ready && q.size() != 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wr_data);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; flush = 0; wr_valid = 0; ir_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; flush = 0; wr_valid = 0; ir_ready = 0;
    tick(); tick();
    rst = 1; #1;
    vec++; if (count !== 3'd0) begin err++; $display("FAIL reset_count got %0d exp 0", count); end
    vec++; if (ir_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", ir_valid); end
    vec++; if (ir_out !== 8'h00) begin err++; $display("FAIL reset_irout got %h exp 00", ir_out); end
    vec++; if (wr_ready !== 1'b1) begin err++; $display("FAIL reset_wrready got %b exp 1", wr_ready); end
    vec++; if ({opcode, operand} !== 8'h00) begin err++; $display("FAIL reset_fields got %h/%h exp 0/0", opcode, operand); end
  endtask

  task automatic test_lda();
    idle(); wr_valid = 1; wr_data = 8'hAA; #1;
    tick();
    wr_valid = 0; #1;
    vec++; if (ir_valid !== 1'b1) begin err++; $display("FAIL lda_valid got %b exp 1", ir_valid); end
    vec++; if (ir_out !== 8'hAA) begin err++; $display("FAIL lda_irout got %h exp aa", ir_out); end
    vec++; if (opcode !== 3'b101) begin err++; $display("FAIL lda_opcode got %b exp 101", opcode); end
    vec++; if (operand !== 5'd10) begin err++; $display("FAIL lda_operand got %0d exp 10", operand); end
    vec++; if (count !== 3'd1) begin err++; $display("FAIL lda_count got %0d exp 1", count); end
    ir_ready = 1; tick(); idle(); #1;
    vec++; if (count !== 3'd0) begin err++; $display("FAIL lda_drain got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_data = 8'h41 + 8'(i); tick();
    end
    wr_valid = 0; #1;
    vec++; if (count !== 3'd4) begin err++; $display("FAIL fill_count got %0d exp 4", count); end
    vec++; if (wr_ready !== 1'b0) begin err++; $display("FAIL fill_wrready got %b exp 0", wr_ready); end
    for (int i = 0; i < 4; i++) begin
      ir_ready = 1; #1;
      vec++; if (ir_out !== 8'h41 + 8'(i)) begin err++; $display("FAIL fill_pop%0d got %h exp %h", i, ir_out, 8'h41 + 8'(i)); end
      tick();
    end
    ir_ready = 0; #1;
    vec++; if (ir_valid !== 1'b0 || ir_out !== 8'h00) begin err++; $display("FAIL fill_empty got %b/%h exp 0/00", ir_valid, ir_out); end
  endtask

  task automatic test_back_to_back();
    idle(); wr_valid = 1; wr_data = 8'h60; tick();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1; ir_ready = 1; wr_data = 8'h61 + 8'(i); #1;
      vec++; if (ir_out !== 8'h60 + 8'(i) || count !== 3'd1) begin
        err++; $display("FAIL stream%0d got %h/%0d exp %h/1", i, ir_out, count, 8'h60 + 8'(i));
      end
      tick();
    end
    wr_valid = 0; #1;
    vec++; if (ir_out !== 8'h6A) begin err++; $display("FAIL stream_last got %h exp 6a", ir_out); end
    ir_ready = 1; tick(); idle();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin wr_valid = 1; wr_data = 8'h20 + 8'(i); tick(); end
    flush = 1; wr_valid = 1; ir_ready = 1; tick();
    idle(); #1;
    vec++; if (count !== 3'd0 || ir_valid !== 1'b0) begin err++; $display("FAIL flush got %0d/%b exp 0/0", count, ir_valid); end
    for (int i = 0; i < 3; i++) begin wr_valid = 1; wr_data = 8'h30 + 8'(i); tick(); end
    rst = 0; wr_valid = 1; ir_ready = 1; tick();
    idle(); #1;
    vec++; if (count !== 3'd0 || ir_valid !== 1'b0) begin err++; $display("FAIL midreset got %0d/%b exp 0/0", count, ir_valid); end
  endtask

`ifdef IR_BYPASS_EN
  task automatic test_bypass();
    idle(); wr_valid = 1; wr_data = 8'h4F; ir_ready = 1; #1;
    vec++; if (ir_valid !== 1'b1 || ir_out !== 8'h4F) begin err++; $display("FAIL bypass got %b/%h exp 1/4f", ir_valid, ir_out); end
    tick(); idle(); #1;
    vec++; if (count !== 3'd0) begin err++; $display("FAIL bypass_count got %0d exp 0", count); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      wr_valid = ($urandom_range(0, 99) < 60);
      ir_ready = ($urandom_range(0, 99) < 50);
      wr_data  = 8'($urandom);
      #1;
      vec++;
      if (count !== 3'(q.size()) || ir_valid !== m_valid() || ir_out !== m_out() ||
          wr_ready !== (q.size() != DEPTH) || {opcode, operand} !== m_out()) begin
        err++;
        $display("FAIL rand%0d got cnt=%0d v=%b out=%h rdy=%b exp cnt=%0d v=%b out=%h rdy=%b",
                 i, count, ir_valid, ir_out, wr_ready, q.size(), m_valid(), m_out(), q.size() != DEPTH);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_lda();
    test_fill();
    test_back_to_back();
    test_flush();
`ifdef IR_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised successor to the single-entry instruction register. Buffers up to DEPTH fetched instruction words in FIFO order between the memory fetch path and the control unit, so fetch can run ahead of execute. Presents the head instruction with pre-split opcode/operand fields under a valid/ready handshake. Supports a flush for taken jumps.

## Interface
- DATA_W, 8: instruction word width.
- OPCODE_W, 3: opcode field width (MSBs of the word); operand width is DATA_W-OPCODE_W.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on next rising edge).
- flush  input  1  discard all queued entries (taken jump).
- wr_valid  input  1  fetch path offers wr_data.
- wr_ready  output  1  queue can accept a word.
- wr_data  input  DATA_W  fetched instruction word.
- ir_valid  output  1  head instruction present.
- ir_ready  input  1  control unit consumes head this cycle.
- ir_out  output  DATA_W  head instruction word.
- opcode  output  OPCODE_W  ir_out[DATA_W-1 -: OPCODE_W].
- operand  output  DATA_W-OPCODE_W  ir_out low bits.
- count  output  $clog2(DEPTH+1)  entries currently held.

## Operation
- Push: wr_valid && wr_ready writes wr_data at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: ir_valid && ir_ready advances rd_ptr mod DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push+pop.
- wr_ready = (count != DEPTH); no combinational dependence on ir_ready. Push while full is not accepted even if a pop occurs that cycle.
- ir_valid = (count != 0) (see Configuration for bypass).
- ir_out = mem[rd_ptr] when ir_valid, else all-zero. opcode/operand are pure slices of ir_out.
- Push while empty with simultaneous ir_ready: only the push takes effect (ir_valid was 0).
- flush=1: pointers and count cleared at the edge; any push/pop that cycle is discarded. flush wins over everything except reset.
- Storage contents are not cleared by reset or flush; only pointers/count.
- Pointer wrap is natural mod DEPTH; no full/empty ambiguity since count is tracked explicitly.

## Timing
- Reset values: count=0, wr_ready=1, ir_valid=0, ir_out=0, opcode=0, operand=0.
- Reset mid-operation: identical to flush; queue empty the cycle after the reset edge.
- Push-to-head latency: 1 cycle (word accepted at edge N is visible on ir_out after edge N when queue was empty).
- Pop takes effect at the edge; next entry visible in the following cycle.
- Sustained throughput: one push and one pop per cycle when 0 < count < DEPTH.
- wr_ready deasserts the cycle after count reaches DEPTH; reasserts the cycle after the first pop from full.

## Configuration
- IR_BYPASS_EN defined: when count==0 and wr_valid, ir_valid=1 and ir_out=wr_data combinationally; if ir_ready is also 1 the word is consumed and not written (count stays 0). Zero-cycle latency on empty queue. flush still suppresses both.
- IR_BYPASS_EN undefined: no bypass; 1-cycle latency as above. All other behaviour identical.

## Structure
- Package instr_q_pkg: default DATA_W/OPCODE_W, opcode constants (LDA=3'b101, ADD=3'b010, remaining ISA opcodes), count-width helper.
- Sub-module iq_storage: DEPTH×DATA_W register array, one write port, one async read port; pointers, count and handshake stay in the top.

## Test plan
- Reset with rst=0 for 2 cycles -> count=0, ir_valid=0, ir_out=8'h00, wr_ready=1.
- Push 8'hAA (LDA 10), no pop -> next cycle ir_valid=1, ir_out=8'hAA, opcode=3'b101, operand=5'd10, count=1.
- Push 5 words 8'h41..8'h45 with ir_ready=0 -> count=4, wr_ready=0, 5th word dropped; pop 4 -> outputs 8'h41..8'h44 in order, then ir_valid=0, ir_out=0.
- Continuous push+pop for 10 words, wrapping pointers twice -> count constant, words emerge in order, no loss.
- Queue holding 3 words, assert flush with wr_valid=1 and ir_ready=1 -> next cycle count=0, ir_valid=0; rst=0 mid-stream gives same result.
- With IR_BYPASS_EN, empty queue, wr_valid=1, wr_data=8'h4F, ir_ready=1 -> same-cycle ir_out=8'h4F, ir_valid=1; next cycle count=0.
